compute_dispatcher: RTL and testbench

Schedules one upstream stream of bottom graphs across `N_CORES` compute cores and merges their results into one result stream. On the input side it grants each core request slot round-robin and delivers the graph exactly `REQUEST_LATENCY` cycles after the request. On the output side it captures each core's `done` pulse in a one-entry holding register and serialises the results round-robin onto a single output port. It sits between the bottom-graph source FIFO and the array of compute cores.

---
 rtl/compute_dispatcher_pkg.sv | 14 +
 rtl/compute_dispatcher_if.sv | 38 +++
 rtl/compute_dispatcher_arb.sv | 33 +++
 rtl/compute_dispatcher.sv | 132 +++++++++++++
 tb/tb_compute_dispatcher.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/compute_dispatcher_pkg.sv
// Shared widths and defaults for the compute dispatcher and its arbiter.
// Constants only; no logic, so no latency or backpressure of its own.
package compute_dispatcher_pkg;

   localparam int BOT_WIDTH               = 128;
   localparam int RESULT_WIDTH            = 6;
   localparam int DEFAULT_REQUEST_LATENCY = 3;

   // Pointer width that stays legal for a single-entry ring.
   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/compute_dispatcher_if.sv
// Bundle of graph-in, core-side and result-out signals of the compute dispatcher.
// Pure wiring: zero latency; backpressure only via coreRequest-driven inReady.
interface compute_dispatcher_if #(
   parameter int N_CORES          = 4,
   parameter int EXTRA_DATA_WIDTH = 14
);
   import compute_dispatcher_pkg::*;

   logic                                 inValid;
   logic [BOT_WIDTH-1:0]                 inBot;
   logic [EXTRA_DATA_WIDTH-1:0]          inExtraData;
   logic                                 inReady;
   logic [N_CORES-1:0]                   coreRequest;
   logic [N_CORES-1:0]                   coreStart;
   logic [BOT_WIDTH-1:0]                 coreBot;
   logic [EXTRA_DATA_WIDTH-1:0]          coreExtraData;
   logic [N_CORES-1:0]                   coreDone;
   logic [RESULT_WIDTH*N_CORES-1:0]      coreResultCount;
   logic [EXTRA_DATA_WIDTH*N_CORES-1:0]  coreResultExtra;
   logic                                 outValid;
   logic [RESULT_WIDTH-1:0]              outCount;
   logic [EXTRA_DATA_WIDTH-1:0]          outExtraData;
   logic                                 overflowError;
   logic                                 idle;

   modport master (
      output inValid, inBot, inExtraData, coreRequest, coreDone, coreResultCount, coreResultExtra,
      input  inReady, coreStart, coreBot, coreExtraData, outValid, outCount, outExtraData,
             overflowError, idle
   );

   modport slave (
      input  inValid, inBot, inExtraData, coreRequest, coreDone, coreResultCount, coreResultExtra,
      output inReady, coreStart, coreBot, coreExtraData, outValid, outCount, outExtraData,
             overflowError, idle
   );

endinterface

// File: rtl/compute_dispatcher_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no backpressure.
module roundRobinArbiter
   import compute_dispatcher_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = ptrWidth(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IW'((int'(ptr) + k) % N);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/compute_dispatcher.sv
// Round-robin graph dispatch to N cores (REQUEST_LATENCY-cycle delivery) and round-robin result merge
// (done -> outValid in 2 cycles); input stalls while no core requests, results never backpressured.
module compute_dispatcher
   import compute_dispatcher_pkg::*;
#(
   parameter int N_CORES          = 4,
   parameter int EXTRA_DATA_WIDTH = 14,
   parameter int REQUEST_LATENCY  = DEFAULT_REQUEST_LATENCY
) (
   input logic                   clk,
   input logic                   rst,
   compute_dispatcher_if.slave   bus
);

   localparam int IW = ptrWidth(N_CORES);

   logic [IW-1:0]               dispPtr;
   logic [N_CORES-1:0]          dispGrant;
   logic [IW-1:0]               dispIdx;
   logic                        dispAny;
   logic                        accept;

   logic [N_CORES-1:0]          grantPipe [REQUEST_LATENCY];
   logic [BOT_WIDTH-1:0]        botPipe   [REQUEST_LATENCY];
   logic [EXTRA_DATA_WIDTH-1:0] extraPipe [REQUEST_LATENCY];
   logic                        pipeBusy;

   logic [N_CORES-1:0]          holdValid;
   logic [RESULT_WIDTH-1:0]     holdCount [N_CORES];
   logic [EXTRA_DATA_WIDTH-1:0] holdExtra [N_CORES];
   logic [IW-1:0]               collPtr;
   logic [N_CORES-1:0]          collGrant;
   logic [IW-1:0]               collIdx;
   logic                        collAny;

   logic                        outValidReg;
   logic [RESULT_WIDTH-1:0]     outCountReg;
   logic [EXTRA_DATA_WIDTH-1:0] outExtraReg;
   logic                        overflowReg;

   roundRobinArbiter #(.N(N_CORES), .IW(IW)) dispArb (
      .req   (bus.coreRequest),
      .ptr   (dispPtr),
      .grant (dispGrant),
      .idx   (dispIdx),
      .any   (dispAny)
   );

   roundRobinArbiter #(.N(N_CORES), .IW(IW)) collArb (
      .req   (holdValid),
      .ptr   (collPtr),
      .grant (collGrant),
      .idx   (collIdx),
      .any   (collAny)
   );

   assign bus.inReady = |bus.coreRequest;
   assign accept      = bus.inValid && dispAny && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         dispPtr <= '0;
         for (int s = 0; s < REQUEST_LATENCY; s++) grantPipe[s] <= '0;
      end else begin
         if (accept) dispPtr <= (dispIdx == IW'(N_CORES - 1)) ? '0 : dispIdx + 1'b1;
         grantPipe[0] <= accept ? dispGrant : '0;
         for (int s = 1; s < REQUEST_LATENCY; s++) grantPipe[s] <= grantPipe[s-1];
      end
   end

   // Payload travels unreset alongside the grant bits; only the grant qualifies it.
   always_ff @(posedge clk) begin
      if (accept) begin
         botPipe[0]   <= bus.inBot;
         extraPipe[0] <= bus.inExtraData;
      end
      for (int s = 1; s < REQUEST_LATENCY; s++) begin
         botPipe[s]   <= botPipe[s-1];
         extraPipe[s] <= extraPipe[s-1];
      end
   end

   assign bus.coreStart     = grantPipe[REQUEST_LATENCY-1];
   assign bus.coreBot       = botPipe[REQUEST_LATENCY-1];
   assign bus.coreExtraData = extraPipe[REQUEST_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         holdValid   <= '0;
         collPtr     <= '0;
         outValidReg <= 1'b0;
         overflowReg <= 1'b0;
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            // A hold being drained this cycle frees its slot for a same-cycle done.
            if (bus.coreDone[i]) begin
               if (holdValid[i] && !collGrant[i]) overflowReg <= 1'b1;
               else                               holdValid[i] <= 1'b1;
            end else if (collGrant[i]) begin
               holdValid[i] <= 1'b0;
            end
         end
         outValidReg <= collAny;
         if (collAny) collPtr <= (collIdx == IW'(N_CORES - 1)) ? '0 : collIdx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CORES; i++) begin
         if (bus.coreDone[i] && (!holdValid[i] || collGrant[i])) begin
            holdCount[i] <= bus.coreResultCount[i*RESULT_WIDTH +: RESULT_WIDTH];
            holdExtra[i] <= bus.coreResultExtra[i*EXTRA_DATA_WIDTH +: EXTRA_DATA_WIDTH];
         end
      end
      if (collAny) begin
         outCountReg <= holdCount[collIdx];
         outExtraReg <= holdExtra[collIdx];
      end
   end

   always_comb begin
      pipeBusy = 1'b0;
      for (int s = 0; s < REQUEST_LATENCY; s++) pipeBusy = pipeBusy | (|grantPipe[s]);
   end

   assign bus.outValid      = outValidReg;
   assign bus.outCount      = outCountReg;
   assign bus.outExtraData  = outExtraReg;
   assign bus.overflowError = overflowReg;
   assign bus.idle          = !pipeBusy && !(|holdValid);

endmodule

// File: tb/tb_compute_dispatcher.sv
// Directed bench for compute_dispatcher: stimulus pushes hand-computed expectations (with target cycle),
// a negedge monitor pops and compares whenever coreStart or outValid is presented.
module tb_compute_dispatcher;

   localparam int N  = 4;
   localparam int EW = 14;
   localparam int L  = 3;

   typedef struct {
      int              cyc;
      logic [N-1:0]    grant;
      logic [127:0]    bot;
      logic [EW-1:0]   extra;
   } startExp_t;

   typedef struct {
      int              cyc;
      logic [5:0]      count;
      logic [EW-1:0]   extra;
   } outExp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   startExp_t startQ[$];
   outExp_t   outQ[$];
   startExp_t se;
   outExp_t   oe;

   compute_dispatcher_if #(.N_CORES(N), .EXTRA_DATA_WIDTH(EW)) bus ();

   compute_dispatcher #(.N_CORES(N), .EXTRA_DATA_WIDTH(EW), .REQUEST_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] botFor(input logic [EW-1:0] tag);
      return {32'hA5A5_A5A5, 18'h0, tag, 32'hDEAD_BEEF ^ {18'h0, tag}, 32'h0123_4567 + {18'h0, tag}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      bus.inValid     = 1'b0;
      bus.coreRequest = '0;
      bus.coreDone    = '0;
   endtask

   task automatic sendGraph(input logic [N-1:0] req, input logic [EW-1:0] tag, input logic [N-1:0] expGrant);
      startExp_t e;
      bus.coreRequest = req;
      bus.inValid     = 1'b1;
      bus.inBot       = botFor(tag);
      bus.inExtraData = tag;
      if (expGrant != '0) begin
         e.cyc   = cyc + L;
         e.grant = expGrant;
         e.bot   = botFor(tag);
         e.extra = tag;
         startQ.push_back(e);
      end
   endtask

   task automatic setDone(input int i, input logic [5:0] cnt, input logic [EW-1:0] ex);
      bus.coreDone[i]                 = 1'b1;
      bus.coreResultCount[i*6 +: 6]   = cnt;
      bus.coreResultExtra[i*EW +: EW] = ex;
   endtask

   task automatic pushOut(input int at, input logic [5:0] cnt, input logic [EW-1:0] ex);
      outExp_t e;
      e.cyc   = at;
      e.count = cnt;
      e.extra = ex;
      outQ.push_back(e);
   endtask

   always @(negedge clk) begin
      if (cyc > 1) begin
         if (bus.coreStart !== '0) begin
            if (startQ.size() == 0) begin
               check("start_unexpected", 128'(bus.coreStart), 128'(0));
            end else begin
               se = startQ.pop_front();
               check("start_cycle", 128'(cyc), 128'(se.cyc));
               check("start_grant", 128'(bus.coreStart), 128'(se.grant));
               check("start_bot", bus.coreBot, se.bot);
               check("start_extra", 128'(bus.coreExtraData), 128'(se.extra));
            end
         end
         if (bus.outValid !== 1'b0) begin
            if (outQ.size() == 0) begin
               check("out_unexpected", 128'(bus.outValid), 128'(0));
            end else begin
               oe = outQ.pop_front();
               check("out_cycle", 128'(cyc), 128'(oe.cyc));
               check("out_count", 128'(bus.outCount), 128'(oe.count));
               check("out_extra", 128'(bus.outExtraData), 128'(oe.extra));
            end
         end
      end
   end

   initial begin
      int c;
      clearIn();
      bus.inBot           = '0;
      bus.inExtraData     = '0;
      bus.coreResultCount = '0;
      bus.coreResultExtra = '0;

      // Reset state; requests during reset must not be accepted.
      bus.coreRequest = 4'b0101;
      bus.inValid     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_inReady", 128'(bus.inReady), 128'(1));
      check("rst_coreStart", 128'(bus.coreStart), 128'(0));
      check("rst_outValid", 128'(bus.outValid), 128'(0));
      check("rst_overflow", 128'(bus.overflowError), 128'(0));
      check("rst_idle", 128'(bus.idle), 128'(1));
      clearIn();
      rst = 1'b0;
      step();

      // All cores requesting: grants rotate 0001,0010,0100,1000,... with tags in order.
      for (int k = 0; k < 8; k++) begin
         sendGraph(4'b1111, EW'(k), 4'b0001 << (k % 4));
         step();
      end
      clearIn();
      repeat (L + 1) step();
      check("idle_after_burst", 128'(bus.idle), 128'(1));

      // Single request from core 1, tag 7: dispPtr moves to 2.
      sendGraph(4'b0010, 14'd7, 4'b0010);
      step();
      clearIn();
      check("idle_busy", 128'(bus.idle), 128'(0));
      repeat (L + 1) step();

      // Requests without valid: ready but no accept, pointer unchanged.
      bus.coreRequest = 4'b1111;
      #1;
      check("ready_no_valid", 128'(bus.inReady), 128'(1));
      step();
      clearIn();
      sendGraph(4'b1111, 14'd9, 4'b0100);
      step();
      sendGraph(4'b1001, 14'd10, 4'b1000);
      step();
      sendGraph(4'b1001, 14'd11, 4'b0001);
      step();
      sendGraph(4'b0000, 14'd12, 4'b0000);
      #1;
      check("not_ready_no_req", 128'(bus.inReady), 128'(0));
      step();
      clearIn();
      repeat (L + 2) step();

      // Four simultaneous dones drain as 1,2,3,4 on consecutive cycles from t+2.
      c = cyc;
      for (int i = 0; i < 4; i++) begin
         setDone(i, 6'(i + 1), EW'(100 + i));
         pushOut(c + 2 + i, 6'(i + 1), EW'(100 + i));
      end
      step();
      clearIn();
      repeat (6) step();
      check("overflow_clear_burst", 128'(bus.overflowError), 128'(0));

      // Core 0 done twice; second arrives while its hold is being drained -> kept.
      c = cyc;
      setDone(0, 6'd30, 14'd200);
      pushOut(c + 2, 6'd30, 14'd200);
      step();
      clearIn();
      setDone(0, 6'd31, 14'd201);
      pushOut(c + 3, 6'd31, 14'd201);
      step();
      clearIn();
      repeat (4) step();
      check("overflow_clear_kept", 128'(bus.overflowError), 128'(0));

      // Cores 1-3 hold results; core 0 done twice, second one lands on an unselected full hold.
      c = cyc;
      setDone(1, 6'd11, 14'd301);
      setDone(2, 6'd12, 14'd302);
      setDone(3, 6'd13, 14'd303);
      pushOut(c + 2, 6'd11, 14'd301);
      pushOut(c + 3, 6'd12, 14'd302);
      pushOut(c + 4, 6'd13, 14'd303);
      step();
      clearIn();
      setDone(0, 6'd20, 14'd320);
      pushOut(c + 5, 6'd20, 14'd320);
      step();
      clearIn();
      setDone(0, 6'd21, 14'd321);
      step();
      clearIn();
      check("overflow_set", 128'(bus.overflowError), 128'(1));
      repeat (5) step();
      check("overflow_sticky", 128'(bus.overflowError), 128'(1));

      // Reset with two graphs in flight and two held results: all discarded.
      sendGraph(4'b0001, 14'd40, 4'b0000);
      step();
      sendGraph(4'b0010, 14'd41, 4'b0000);
      setDone(2, 6'd50, 14'd350);
      setDone(3, 6'd51, 14'd351);
      step();
      clearIn();
      rst = 1'b1;
      bus.coreRequest = 4'b1111;
      bus.inValid     = 1'b1;
      #1;
      check("rst_mid_inReady", 128'(bus.inReady), 128'(1));
      step();
      check("rst_mid_coreStart", 128'(bus.coreStart), 128'(0));
      check("rst_mid_idle", 128'(bus.idle), 128'(1));
      step();
      clearIn();
      rst = 1'b0;
      step();
      check("post_rst_idle", 128'(bus.idle), 128'(1));
      check("post_rst_overflow", 128'(bus.overflowError), 128'(0));
      repeat (6) step();

      // Both pointers restart at 0 after reset.
      c = cyc;
      sendGraph(4'b1111, 14'd60, 4'b0001);
      setDone(1, 6'd6, 14'd401);
      setDone(0, 6'd5, 14'd400);
      pushOut(c + 2, 6'd5, 14'd400);
      pushOut(c + 3, 6'd6, 14'd401);
      step();
      clearIn();

      for (int k = 0; k < 20 && (startQ.size() != 0 || outQ.size() != 0); k++) step();
      check("start_queue_left", 128'(startQ.size()), 128'(0));
      check("out_queue_left", 128'(outQ.size()), 128'(0));
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
